// File: rtl/kyber_encode_pkg.sv
// Shared constants, FSM state type and small helpers for the streaming ByteEncode_d block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package kyber_encode_pkg;

    localparam int KYBER_N = 256;
    localparam int KYBER_Q = 3329;
    localparam int D_MAX   = 12;
    // Worst case fill: 12 bits still held plus a fresh 12-bit coefficient
    localparam int ACC_W   = 24;
    localparam int CNT_W   = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // d is usable when it lies in 1..D_MAX
    function automatic logic d_legal(input logic [3:0] d);
        return (d != 4'd0) && (d <= 4'(D_MAX));
    endfunction

    // Mask keeping the low d bits of a D_MAX-wide field
    function automatic logic [D_MAX-1:0] bit_mask(input logic [3:0] d);
        return {D_MAX{1'b1}} >> (4'(D_MAX) - d);
    endfunction

endpackage

// File: rtl/byte_encode_stream_if.sv
// Coefficient-in / byte-out stream bundle for the encoder.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both streams; master is the environment, slave is the encoder.
interface byte_encode_stream_if;

    logic        coef_valid;
    logic        coef_ready;
    logic [15:0] coef_data;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic        byte_last;

    modport master (
        output coef_valid, coef_data, byte_ready,
        input  coef_ready, byte_valid, byte_data, byte_last
    );

    modport slave (
        input  coef_valid, coef_data, byte_ready,
        output coef_ready, byte_valid, byte_data, byte_last
    );

endinterface

// File: rtl/encode_bitpacker.sv
// Bit accumulator: appends d-bit fields at the fill point, retires bytes from the bottom.
// Latency: appended bits are visible in byte_dat/cnt the cycle after push.
// Backpressure: none internally; caller only pushes while cnt <= 12 and pops while cnt >= 8.
module encode_bitpacker
    import kyber_encode_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [D_MAX-1:0] bits,
    input  logic [3:0]       d,
    output logic [7:0]       byte_dat,
    output logic [CNT_W-1:0] cnt
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_nxt;

    // Retire a byte first, then place the new field at the post-retire fill point
    always_comb begin
        acc_base = pop ? (acc >> 8) : acc;
        cnt_base = pop ? (cnt - 5'd8) : cnt;
        acc_nxt  = acc_base;
        cnt_nxt  = cnt_base;
        if (push) begin
            acc_nxt = acc_base | ({{(ACC_W-D_MAX){1'b0}}, bits} << cnt_base);
            cnt_nxt = cnt_base + {1'b0, d};
        end
    end

    // Accumulator and fill count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
        end
    end

    assign byte_dat = acc[7:0];

endmodule

// File: rtl/byte_encode_stream.sv
// Streaming ByteEncode_d: packs low d bits of 256 coefficients LSB-first into 32*d bytes.
// Latency: a byte is offered the cycle after the coefficient accept that completed it.
// Backpressure: coef_ready depends on registered state only; byte_valid/data hold until accepted.
// Build option BYTE_ENCODE_MODQ_EN: for d==12, reduce each coefficient once into [0,q) first.
module byte_encode_stream
    import kyber_encode_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           d_sel,
    output logic                 busy,
    output logic                 err,
    output logic                 done,
    byte_encode_stream_if.slave  bus
);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       d_reg;
    logic [8:0]       coef_cnt;
    logic [8:0]       byte_cnt;
    logic [8:0]       n_bytes;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       acc_byte;
    logic             start_ok;
    logic             coef_fire;
    logic             byte_fire;
    logic             last_coef;
    logic             last_byte;
    logic [15:0]      coef_red;
    logic [D_MAX-1:0] coef_bits;
    logic             unused_coef_hi;

    assign start_ok  = (state == S_IDLE) && start && d_legal(d_sel);
    assign coef_fire = bus.coef_valid && bus.coef_ready;
    assign byte_fire = bus.byte_valid && bus.byte_ready;
    assign n_bytes   = {d_reg, 5'b0};
    assign last_coef = coef_fire && (coef_cnt == 9'(KYBER_N - 1));
    assign last_byte = byte_fire && (byte_cnt == n_bytes - 9'd1);

`ifdef BYTE_ENCODE_MODQ_EN
    localparam logic signed [15:0] Q16 = 16'(KYBER_Q);
    logic signed [15:0] coef_s;
    assign coef_s = bus.coef_data;

    // Single conditional add/subtract of q brings supported inputs into [0,q)
    always_comb begin
        coef_red = coef_s;
        if (d_reg == 4'd12) begin
            if (coef_s < 16'sd0) begin
                coef_red = coef_s + Q16;
            end else if (coef_s >= Q16) begin
                coef_red = coef_s - Q16;
            end
        end
    end
`else
    assign coef_red = bus.coef_data;
`endif

    // Two's-complement low bits; anything above d is cleared before packing
    assign coef_bits      = coef_red[D_MAX-1:0] & bit_mask(d_reg);
    assign unused_coef_hi = ^coef_red[15:D_MAX];

    encode_bitpacker u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_ok),
        .push     (coef_fire),
        .pop      (byte_fire),
        .bits     (coef_bits),
        .d        (d_reg),
        .byte_dat (acc_byte),
        .cnt      (cnt)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and stream-side outputs from registered state
    always_comb begin
        state_nxt      = state;
        busy           = (state != S_IDLE);
        done           = (state == S_DONE);
        bus.coef_ready = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        bus.byte_data  = acc_byte;
        if ((state == S_RUN) && (coef_cnt < 9'(KYBER_N)) && (cnt <= 5'd12)) begin
            bus.coef_ready = 1'b1;
        end
        if (((state == S_RUN) || (state == S_DRAIN)) && (cnt >= 5'd8)) begin
            bus.byte_valid = 1'b1;
            bus.byte_last  = (byte_cnt == n_bytes - 9'd1);
        end
        case (state)
            S_IDLE:  if (start_ok)  state_nxt = S_RUN;
            S_RUN:   if (last_coef) state_nxt = S_DRAIN;
            S_DRAIN: if (last_byte) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Latched width and coefficient/byte counters, cleared on each accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_reg    <= '0;
            coef_cnt <= '0;
            byte_cnt <= '0;
        end else if (start_ok) begin
            d_reg    <= d_sel;
            coef_cnt <= '0;
            byte_cnt <= '0;
        end else begin
            if (coef_fire) coef_cnt <= coef_cnt + 9'd1;
            if (byte_fire) byte_cnt <= byte_cnt + 9'd1;
        end
    end

    // One-cycle error pulse for a start carrying an unusable width
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= (state == S_IDLE) && start && !d_legal(d_sel);
        end
    end

endmodule

// File: tb/tb_byte_encode_stream.sv
// Directed bench for byte_encode_stream: known coefficient patterns, hand-derived byte streams.
// Latency: checks one-byte-per-cycle timing and done one cycle after the last byte.
// Backpressure: exercises a toggling byte_ready and checks data holds while stalled.
module tb_byte_encode_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] d_sel = 4'd0;
    logic       busy;
    logic       err;
    logic       done;

    byte_encode_stream_if bus();

    byte_encode_stream dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .d_sel (d_sel),
        .busy  (busy),
        .err   (err),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] coef_mem [0:255];
    logic [7:0]  got_dat  [0:383];
    logic        got_last [0:383];
    logic [7:0]  neg_pat  [0:2];
    int          nb;
    int          done_cyc;
    int          last_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start a polynomial at width d and stream it through; inputs driven and outputs sampled on negedge
    task automatic run_poly(input int d, input bit toggle, input int max_cyc);
        int         ci;
        int         cyc;
        bit         stall_pend;
        bit         done_seen;
        logic [7:0] stall_dat;
        start = 1'b1;
        d_sel = d[3:0];
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        ci = 0; cyc = 0; nb = 0;
        done_seen = 0; stall_pend = 0; stall_dat = 8'h00;
        done_cyc = -1; last_cyc = -1;
        while (!done_seen && cyc < max_cyc) begin
            bus.byte_ready = toggle ? cyc[0] : 1'b1;
            bus.coef_valid = (ci < 256);
            bus.coef_data  = (ci < 256) ? coef_mem[ci] : 16'h0000;
            if (stall_pend) begin
                chk("stall_valid", bus.byte_valid, 1);
                chk("stall_data", bus.byte_data, stall_dat);
            end
            stall_pend = 0;
            if (bus.byte_valid) begin
                if (bus.byte_ready) begin
                    if (nb < 384) begin
                        got_dat[nb]  = bus.byte_data;
                        got_last[nb] = bus.byte_last;
                    end
                    if (bus.byte_last) last_cyc = cyc;
                    nb++;
                end else begin
                    stall_pend = 1;
                    stall_dat  = bus.byte_data;
                end
            end
            if (bus.coef_valid && bus.coef_ready) ci++;
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        bus.coef_valid = 1'b0;
        bus.byte_ready = 1'b0;
        chk("done_seen", done_seen, 1);
        chk("byte_count", nb, 32 * d);
        chk("done_after_last", done_cyc, last_cyc + 1);
        chk("busy_back_idle", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_coef_ready"}, bus.coef_ready, 0);
        chk({tag, "_byte_valid"}, bus.byte_valid, 0);
        chk({tag, "_byte_data"}, bus.byte_data, 0);
        chk({tag, "_byte_last"}, bus.byte_last, 0);
    endtask

    task automatic check_d8_ramp(input string tag);
        for (int i = 0; i < 256; i++) coef_mem[i] = 16'(i);
        run_poly(8, 1'b0, 2000);
        chk({tag, "_cycles"}, done_cyc, 257);
        for (int i = 0; i < 256; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), got_dat[i], i);
            chk($sformatf("%s_last%0d", tag, i), got_last[i], (i == 255) ? 1 : 0);
        end
    endtask

    initial begin
        bus.coef_valid = 1'b0;
        bus.coef_data  = 16'h0000;
        bus.byte_ready = 1'b0;
`ifdef BYTE_ENCODE_MODQ_EN
        // -1 reduces to 3328 = 0xD00; a pair packs to 0xD00D00
        neg_pat[0] = 8'h00; neg_pat[1] = 8'h0D; neg_pat[2] = 8'hD0;
`else
        neg_pat[0] = 8'hFF; neg_pat[1] = 8'hFF; neg_pat[2] = 8'hFF;
`endif
        repeat (3) @(negedge clk);
        chk_idle_outputs("in_reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("after_reset");

        // Illegal widths: err pulses, machine stays idle
        start = 1'b1; d_sel = 4'd13;
        @(negedge clk);
        start = 1'b0;
        chk("err13_pulse", err, 1);
        chk("err13_busy", busy, 0);
        @(negedge clk);
        chk("err13_clear", err, 0);
        start = 1'b1; d_sel = 4'd0;
        @(negedge clk);
        start = 1'b0;
        chk("err0_pulse", err, 1);
        chk("err0_busy", busy, 0);
        @(negedge clk);

        // d=8 ramp: bytes equal coefficient index
        check_d8_ramp("d8");

        // d=1 alternating 1,0 -> 0x55 bytes
        for (int i = 0; i < 256; i++) coef_mem[i] = (i % 2 == 0) ? 16'h0001 : 16'h0000;
        run_poly(1, 1'b0, 2000);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("d1_byte%0d", i), got_dat[i], 8'h55);
            chk($sformatf("d1_last%0d", i), got_last[i], (i == 31) ? 1 : 0);
        end

        // d=12 with two known coefficients then zeros; upper nibble must be dropped
        for (int i = 0; i < 256; i++) coef_mem[i] = 16'h0000;
        coef_mem[0] = 16'hFABC;
        coef_mem[1] = 16'h0123;
        run_poly(12, 1'b0, 2000);
        chk("d12_byte0", got_dat[0], 8'hBC);
        chk("d12_byte1", got_dat[1], 8'h3A);
        chk("d12_byte2", got_dat[2], 8'h12);
        chk("d12_byte3", got_dat[3], 8'h00);
        chk("d12_last382", got_last[382], 0);
        chk("d12_last383", got_last[383], 1);

        // d=4 under toggling byte_ready, upper bits of coefficient set
        for (int i = 0; i < 256; i++) coef_mem[i] = 16'h00FF;
        run_poly(4, 1'b1, 2000);
        for (int i = 0; i < 128; i++) chk($sformatf("d4_byte%0d", i), got_dat[i], 8'hFF);
        chk("d4_last127", got_last[127], 1);

        // d=12 with negative coefficients
        for (int i = 0; i < 256; i++) coef_mem[i] = 16'hFFFF;
        run_poly(12, 1'b0, 2000);
        for (int i = 0; i < 384; i++) chk($sformatf("neg_byte%0d", i), got_dat[i], neg_pat[i % 3]);

        // Reset in the middle of a run, then a clean run
        for (int i = 0; i < 256; i++) coef_mem[i] = 16'(i);
        start = 1'b1; d_sel = 4'd2;
        @(negedge clk);
        start = 1'b0;
        bus.coef_valid = 1'b1;
        bus.coef_data  = 16'h0003;
        bus.byte_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrun_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk_idle_outputs("midrun_rst");
        bus.coef_valid = 1'b0;
        bus.byte_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("post_rst");
        check_d8_ramp("rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
